// File: rtl/alt_pfl_cfg_rsu_recovery.sv
// RSU recovery controller: on a watchdog timeout or configuration failure, pulses
// pfl_nreconfigure low to reload the factory page. Retries are bounded, after which it locks out.
module alt_pfl_cfg_rsu_recovery #(
    parameter int PAGE_WIDTH    = 3,
    parameter int FACTORY_PAGE  = 0,
    parameter int NRECONF_PULSE = 16,
    parameter int CONF_TIMEOUT  = 1000000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PAGE_WIDTH-1:0]              app_page,
    input  logic                               watchdog_timed_out,
    input  logic                               fpga_conf_done,
    input  logic                               fpga_nstatus,
    output logic                               pfl_nreconfigure,
    output logic [PAGE_WIDTH-1:0]              page_sel,
    output logic                               recovery_active,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   fail_count,
    output logic                               recovery_exhausted,
    output logic [2:0]                         state_dbg
);

    localparam int FCW     = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = (NRECONF_PULSE > CONF_TIMEOUT) ? NRECONF_PULSE : CONF_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]         PULSE_LAST   = CW'(NRECONF_PULSE - 1);
    localparam logic [CW-1:0]         TIMEOUT_LAST = CW'(CONF_TIMEOUT - 1);
    localparam logic [FCW-1:0]        FAIL_MAX     = FCW'(MAX_RETRIES);
    localparam logic [PAGE_WIDTH-1:0] FACTORY      = PAGE_WIDTH'(FACTORY_PAGE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MONITOR   = 3'd1,
        S_PULSE     = 3'd2,
        S_WAIT_CONF = 3'd3,
        S_LOCKOUT   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    seen_low_q, seen_low_d;
    logic                    wd_q, ns_q;
    logic                    wd_rise, ns_fall, conf_ok, timed_out, take_fail, at_max;
    logic                    nreconf_d, active_d, exhausted_d;
    logic [FCW-1:0]          fail_count_d;
    logic [PAGE_WIDTH-1:0]   page_sel_d;

    assign wd_rise   = watchdog_timed_out & ~wd_q;
    assign ns_fall   = ~fpga_nstatus & ns_q;
    assign conf_ok   = seen_low_q & fpga_conf_done & fpga_nstatus;
    assign timed_out = (cnt_q == TIMEOUT_LAST);
    assign at_max    = (fail_count == FAIL_MAX);
    assign state_dbg = state_q;

    // A successful configuration in the same cycle as the timeout wins over the timeout.
    assign take_fail = ((state_q == S_MONITOR) && (wd_rise || ns_fall)) ||
                       ((state_q == S_WAIT_CONF) && !conf_ok && (ns_fall || timed_out));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            cnt_q              <= '0;
            seen_low_q         <= 1'b0;
            wd_q               <= 1'b0;
            ns_q               <= 1'b0;
            pfl_nreconfigure   <= 1'b1;
            page_sel           <= app_page;
            recovery_active    <= 1'b0;
            fail_count         <= '0;
            recovery_exhausted <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            seen_low_q         <= seen_low_d;
            wd_q               <= watchdog_timed_out;
            ns_q               <= fpga_nstatus;
            pfl_nreconfigure   <= nreconf_d;
            page_sel           <= page_sel_d;
            recovery_active    <= active_d;
            fail_count         <= fail_count_d;
            recovery_exhausted <= exhausted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_MONITOR;
            S_MONITOR:   if (take_fail) state_d = at_max ? S_LOCKOUT : S_PULSE;
            S_PULSE:     if (cnt_q == PULSE_LAST) state_d = S_WAIT_CONF;
            S_WAIT_CONF: begin
                if (conf_ok)        state_d = S_MONITOR;
                else if (take_fail) state_d = at_max ? S_LOCKOUT : S_PULSE;
            end
            S_LOCKOUT:   state_d = S_LOCKOUT;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        cnt_d        = '0;
        seen_low_d   = seen_low_q;
        fail_count_d = fail_count;
        page_sel_d   = page_sel;
        nreconf_d    = (state_d != S_PULSE);
        active_d     = (state_d == S_PULSE) || (state_d == S_WAIT_CONF);
        exhausted_d  = (state_d == S_LOCKOUT);

        if ((state_d == state_q) && ((state_q == S_PULSE) || (state_q == S_WAIT_CONF)))
            cnt_d = cnt_q + CW'(1);

        if (take_fail) begin
            seen_low_d = 1'b0;
            page_sel_d = FACTORY;
            if (!at_max)
                fail_count_d = fail_count + FCW'(1);
        end else if (state_q == S_WAIT_CONF) begin
            seen_low_d = seen_low_q | ~fpga_conf_done;
        end
    end

endmodule

// File: tb/tb_alt_pfl_cfg_rsu_recovery.sv
// Bench for alt_pfl_cfg_rsu_recovery: an absolute-time recovery model plus directed scenarios
// with hand-computed cycle numbers, followed by randomized watchdog/nstatus/conf_done traffic.
module tb_alt_pfl_cfg_rsu_recovery;

    localparam int PW    = 3;
    localparam int FACT  = 0;
    localparam int P     = 16;
    localparam int T     = 50;
    localparam int MAXR  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [PW-1:0] app_page = '0;
    logic          watchdog_timed_out = 1'b0;
    logic          fpga_conf_done = 1'b1;
    logic          fpga_nstatus = 1'b1;
    logic          pfl_nreconfigure;
    logic [PW-1:0] page_sel;
    logic          recovery_active;
    logic [1:0]    fail_count;
    logic          recovery_exhausted;
    logic [2:0]    state_dbg;

    int total = 0;
    int bad   = 0;

    alt_pfl_cfg_rsu_recovery #(
        .PAGE_WIDTH(PW), .FACTORY_PAGE(FACT), .NRECONF_PULSE(P),
        .CONF_TIMEOUT(T), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .app_page(app_page),
        .watchdog_timed_out(watchdog_timed_out), .fpga_conf_done(fpga_conf_done),
        .fpga_nstatus(fpga_nstatus), .pfl_nreconfigure(pfl_nreconfigure),
        .page_sel(page_sel), .recovery_active(recovery_active), .fail_count(fail_count),
        .recovery_exhausted(recovery_exhausted), .state_dbg(state_dbg)
    );

    // ---------------- clock / guard ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL time_limit: got timeout expected finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d (state_dbg=%0d)",
                     name, $time, got, exp, state_dbg);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is the posedge index mc. A recovery is described by the absolute cycle
    // range of its pulse; the wait window follows it and ends T cycles later.
    int   mc = 0;
    bit   m_valid = 0;
    int   m_idle = 0;
    bit   m_rec = 0;
    bit   m_locked = 0;
    int   m_pulse_last = 0;
    bit   m_saw_low = 0;
    int   m_fails = 0;
    int   m_page = 0;
    bit   m_wd_prev = 0;
    bit   m_ns_prev = 0;

    task automatic model_fail(input int c);
        if (m_fails == MAXR) begin
            m_locked = 1;
            m_rec    = 0;
        end else begin
            m_fails++;
            m_page       = FACT;
            m_rec        = 1;
            m_pulse_last = c + P;
            m_saw_low    = 0;
        end
    endtask

    always @(posedge clk) begin
        bit wd_rise, ns_fall, monitoring, in_wait;
        mc++;
        if (reset) begin
            m_valid   = 1;
            m_page    = int'(app_page);
            m_fails   = 0;
            m_locked  = 0;
            m_rec     = 0;
            m_idle    = mc + 1;
            m_wd_prev = 0;
            m_ns_prev = 0;
            m_saw_low = 0;
        end else if (m_valid) begin
            wd_rise    = watchdog_timed_out && !m_wd_prev;
            ns_fall    = !fpga_nstatus && m_ns_prev;
            monitoring = !m_rec && !m_locked && (mc > m_idle);
            in_wait    = m_rec && (mc > m_pulse_last);
            if (monitoring && (wd_rise || ns_fall)) begin
                model_fail(mc);
            end else if (in_wait) begin
                if (m_saw_low && fpga_conf_done && fpga_nstatus) m_rec = 0;
                else if (ns_fall || (mc == m_pulse_last + T))   model_fail(mc);
                else if (!fpga_conf_done)                        m_saw_low = 1;
            end
            m_wd_prev = watchdog_timed_out;
            m_ns_prev = fpga_nstatus;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("nreconf",    int'(pfl_nreconfigure),   (m_rec && (mc + 1 <= m_pulse_last)) ? 0 : 1);
            check("page_sel",   int'(page_sel),           m_page);
            check("active",     int'(recovery_active),    int'(m_rec));
            check("fail_count", int'(fail_count),         m_fails);
            check("exhausted",  int'(recovery_exhausted), int'(m_locked));
        end
    end

    // ---------------- driver tasks ----------------
    int cyc  = 0;
    int lows = 0;

    // Leaves the bench in cycle 0, the IDLE cycle right after reset.
    task automatic do_reset(input int page);
        @(negedge clk);
        reset = 1'b1;
        app_page = PW'(page);
        watchdog_timed_out = 1'b0;
        fpga_nstatus = 1'b1;
        fpga_conf_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc  = 0;
        lows = 0;
    endtask

    task automatic go(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
            if (!pfl_nreconfigure) lows++;
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        // quiet after reset: application page stays selected
        do_reset(5);
        go(100);
        check("quiet_page", int'(page_sel), 5);
        check("quiet_nreconf", int'(pfl_nreconfigure), 1);
        check("quiet_fails", int'(fail_count), 0);

        // watchdog at cycle 10, configuration completes at cycle 40
        do_reset(5);
        go(10); watchdog_timed_out = 1'b1; fpga_conf_done = 1'b0;
        go(11);
        check("wd_pulse_start", int'(pfl_nreconfigure), 0);
        check("wd_page", int'(page_sel), 0);
        check("wd_fails", int'(fail_count), 1);
        check("wd_active", int'(recovery_active), 1);
        go(26); check("wd_pulse_last", int'(pfl_nreconfigure), 0);
        go(27); check("wd_pulse_end", int'(pfl_nreconfigure), 1);
        check("wd_waiting", int'(recovery_active), 1);
        go(40); fpga_conf_done = 1'b1;
        go(41); check("wd_done", int'(recovery_active), 0);
        check("wd_fails_kept", int'(fail_count), 1);
        check("wd_page_kept", int'(page_sel), 0);

        // conf_done never drops: timeouts until lockout
        do_reset(2);
        go(10); watchdog_timed_out = 1'b1;
        go(76); check("to_still_high", int'(pfl_nreconfigure), 1);
        go(77); check("to_second_pulse", int'(pfl_nreconfigure), 0);
        check("to_fails2", int'(fail_count), 2);
        go(143); check("to_third_pulse", int'(pfl_nreconfigure), 0);
        go(208); check("to_not_locked", int'(recovery_exhausted), 0);
        go(209); check("to_locked", int'(recovery_exhausted), 1);
        check("to_locked_idle", int'(recovery_active), 0);
        go(215); watchdog_timed_out = 1'b0;
        go(220); watchdog_timed_out = 1'b1;
        go(260);
        check("to_low_cycles", lows, 3 * P);
        check("to_fails3", int'(fail_count), 3);

        // simultaneous watchdog rise and nstatus fall
        do_reset(4);
        go(10); watchdog_timed_out = 1'b1; fpga_nstatus = 1'b0;
        go(11); check("both_fails", int'(fail_count), 1);
        go(12); fpga_nstatus = 1'b1;
        go(27); check("both_end", int'(pfl_nreconfigure), 1);
        go(40); check("both_lows", lows, P);
        check("both_fails_once", int'(fail_count), 1);

        // reset in the 5th pulse cycle
        do_reset(3);
        go(10); watchdog_timed_out = 1'b1;
        go(15); reset = 1'b1; app_page = 3'd6;
        go(16);
        check("rst_nreconf", int'(pfl_nreconfigure), 1);
        check("rst_fails", int'(fail_count), 0);
        check("rst_page", int'(page_sel), 6);
        check("rst_active", int'(recovery_active), 0);
        reset = 1'b0;
        go(20);

        // randomized traffic
        for (int ep = 0; ep < 5; ep++) begin
            do_reset(int'($urandom_range(0, 7)));
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if ($urandom_range(0, 39) == 0) watchdog_timed_out = ~watchdog_timed_out;
                fpga_nstatus = ($urandom_range(0, 29) != 0);
                if ($urandom_range(0, 7) == 0) fpga_conf_done = ~fpga_conf_done;
                app_page = PW'($urandom_range(0, 7));
                reset = ($urandom_range(0, 499) == 0);
            end
            reset = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
